// File: rtl/bcd_subtractor_serial.sv
// Digit-serial packed-BCD subtractor: diff = (a - b) mod 10^DIGITS.
// One digit per clock, least-significant first, with a ripple borrow.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request, sampled only while idle
//   a, b       minuend / subtrahend, packed BCD, digit 0 in [3:0]
//   diff       result, packed BCD, held until the next completion
//   borrow_out set when a < b (result wrapped)
//   invalid    set when any captured digit of a or b exceeded 9
//   busy       high from the cycle after start through the done cycle
//   done       one-cycle pulse marking diff/borrow_out/invalid valid
module bcd_subtractor_serial #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  borrow_out,
  output logic                  invalid,
  output logic                  busy,
  output logic                  done
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  logic [1:0]    state;
  logic [W-1:0]  a_r, b_r, res;
  logic [IW-1:0] idx;
  logic          br;

  // Any input digit outside 0..9 poisons the whole operation.
  logic bad;
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
    end
  end

  // Operands shift right each RUN cycle, so the current digit is always [3:0].
  // t is 5-bit two's complement; bit 4 set means the digit went negative.
  logic [4:0]   t;
  logic [3:0]   dig;
  logic         br_nxt;
  logic [W+3:0] cat;
  logic [W-1:0] res_nxt;
  always_comb begin
    t       = {1'b0, a_r[3:0]} - {1'b0, b_r[3:0]} - {4'b0, br};
    br_nxt  = t[4];
    dig     = t[4] ? (t[3:0] + 4'd10) : t[3:0];
    // New digit enters at the top; after DIGITS shifts digit 0 lands in [3:0].
    cat     = {dig, res};
    res_nxt = cat[W+3:4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      res        <= '0;
      idx        <= '0;
      br         <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      invalid    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r <= a;
          b_r <= b;
          res <= '0;
          idx <= '0;
          br  <= 1'b0;
          if (bad) begin
            diff       <= '0;
            borrow_out <= 1'b0;
            invalid    <= 1'b1;
            state      <= DONE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          a_r <= a_r >> 4;
          b_r <= b_r >> 4;
          res <= res_nxt;
          br  <= br_nxt;
          idx <= idx + IW'(1);
          if (idx == LAST) begin
            diff       <= res_nxt;
            borrow_out <= br_nxt;
            invalid    <= 1'b0;
            state      <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
module tb_bcd_subtractor_serial;

  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, b, diff;
  logic         borrow_out, invalid, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_subtractor_serial #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .diff(diff), .borrow_out(borrow_out), .invalid(invalid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bo;
    logic         inv;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives start at the next falling edge, then counts cycles (cycle 1 is the
  // first after the start edge) until done is seen or the budget runs out.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        output int lat, output int nbusy);
    int cyc;
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    @(posedge clk);
    cyc = 0; nbusy = 0; lat = -1;
    while (cyc < 20) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (busy) nbusy++;
      if (done) begin lat = cyc; break; end
    end
    if (lat < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: no done for a=%h b=%h", va, vb);
    end
  endtask

  vec_t vecs[9];

  initial begin
    int lat, nb, cyc;
    logic seen;

    vecs[0] = '{16'h4321, 16'h1234, 16'h3087, 1'b0, 1'b0, 5};
    vecs[1] = '{16'h0000, 16'h0001, 16'h9999, 1'b1, 1'b0, 5};
    vecs[2] = '{16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 5};
    vecs[3] = '{16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0, 5};
    vecs[4] = '{16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 1};
    vecs[5] = '{16'h0005, 16'h0009, 16'h9996, 1'b1, 1'b0, 5};
    vecs[6] = '{16'h5000, 16'h4999, 16'h0001, 1'b0, 1'b0, 5};
    vecs[7] = '{16'h1234, 16'h00F0, 16'h0000, 1'b0, 1'b1, 1};
    vecs[8] = '{16'h9876, 16'h0123, 16'h9753, 1'b0, 1'b0, 5};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset diff", diff, 0);
    check("reset borrow", borrow_out, 0);
    check("reset invalid", invalid, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, lat, nb);
      check($sformatf("v%0d diff", i), diff, vecs[i].d);
      check($sformatf("v%0d borrow", i), borrow_out, vecs[i].bo);
      check($sformatf("v%0d invalid", i), invalid, vecs[i].inv);
      check($sformatf("v%0d latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d busy cycles", i), nb, vecs[i].lat);
    end

    // Second start mid-operation (and changing operands) must be ignored.
    @(negedge clk);
    a = 16'h4321; b = 16'h1234; start = 1'b1;
    @(posedge clk);
    cyc = 0; lat = -1;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 2);
      if (cyc == 2) begin a = 16'h9999; b = 16'h0000; end
      if (done) begin lat = cyc; break; end
    end
    check("ignore latency", lat, 5);
    check("ignore diff", diff, 16'h3087);
    check("ignore borrow", borrow_out, 0);
    @(negedge clk);
    check("idle after done", busy, 0);
    @(negedge clk);
    check("no queued op", busy, 0);

    // Reset at cycle 3 aborts: no done, outputs cleared.
    @(negedge clk);
    a = 16'h0000; b = 16'h0001; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort done", done, 0);
    check("abort busy", busy, 0);
    check("abort diff", diff, 0);
    check("abort borrow", borrow_out, 0);
    check("abort invalid", invalid, 0);
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (done || busy) seen = 1'b1; end
    check("abort stays idle", seen, 0);

    // rst wins over a simultaneous start.
    a = 16'h0002; b = 16'h0001; start = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    check("rst beats start", busy, 0);

    // Back-to-back: new start in the cycle right after done.
    run_op(16'h0050, 16'h0051, lat, nb);
    check("b2b first diff", diff, 16'h9999);
    check("b2b first borrow", borrow_out, 1);
    run_op(16'h2000, 16'h0999, lat, nb);
    check("b2b second latency", lat, 5);
    check("b2b second diff", diff, 16'h1001);
    check("b2b second borrow", borrow_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
